time_counter: RTL and testbench
===============================

Name: time_counter

Overview:
Timekeeping core of the digital clock. It divides the system clock to a 1 Hz tick and keeps the seconds, minutes and hours count (24 h format). A two-button set mode lets the user adjust hours and minutes. Its binary outputs feed directly into the per-digit BCD/7-segment converter stages (seconds, minutes, hours converters).

Parameters:
TICK_DIV, 50000000, number of clk cycles per 1 s tick; must be ≥2.
DIV_W, 26, width of the prescaler counter; must satisfy 2^DIV_W ≥ TICK_DIV.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst  input  1  asynchronous, active-low reset (0 = reset).
btn_mode  input  1  mode button level; already synchronised and debounced upstream.
btn_inc  input  1  increment button level; already synchronised and debounced upstream.
sec_val  output  6  seconds, 0..59.
min_val  output  6  minutes, 0..59.
hour_val  output  5  hours, 0..23.
set_mode  output  2  current state: 0 = RUN, 1 = SET_HOUR, 2 = SET_MIN.
tick_1hz  output  1  one-cycle pulse on each prescaler terminal count.

Behaviour:
- Reset (rst=0, asynchronous assert, synchronous release on the next clk edge):
  - sec_val=0, min_val=0, hour_val=0.
  - Prescaler=0, tick_1hz=0, set_mode=RUN.
  - Button edge-detect registers=0.
  - Reset mid-operation (any state) aborts immediately to these values.
- All outputs are registered; no combinational path from inputs to outputs.
- Edge detect: an event is a rising edge of the button (level 1 now, registered level 0 last cycle). A held button gives exactly one event.
- Prescaler:
  - In RUN it counts 0..TICK_DIV-1 and wraps.
  - tick_1hz=1 for the single cycle following the cycle where the count equals TICK_DIV-1.
  - In SET_HOUR/SET_MIN the prescaler is held at 0 and tick_1hz=0.
- RUN, on an internal tick (same cycle tick_1hz is asserted):
  - sec_val +1.
  - sec 59 → 0 with min +1.
  - min 59 → 0 with hour +1.
  - hour 23 → 0.
  - 23:59:59 → 00:00:00 in one tick.
- FSM:
  - RUN --mode event--> SET_HOUR --mode event--> SET_MIN --mode event--> RUN.
  - set_mode is 3 is unreachable; if encountered, go to RUN.
- Set states:
  - An inc event increments the selected field by 1 in the cycle after the edge.
  - Wrap without carry: hour 23 → 0, min 59 → 0.
  - sec_val is frozen.
- Leaving SET_MIN → RUN: sec_val cleared to 0 and prescaler restarts at 0, so the first tick arrives TICK_DIV cycles later.
- Simultaneous mode and inc events in the same cycle: mode wins, inc is discarded.
- inc events in RUN are ignored. Mode events take effect in the cycle after the edge.
- Widths: counters compare with == against constants. No value outside its range is ever produced.

Test Plan:
1. rst=0 for 3 cycles mid-count, then release → all value outputs 0, set_mode=0, tick_1hz=0; first tick_1hz arrives TICK_DIV cycles after release.
2. TICK_DIV=4, RUN for 240 cycles after reset → exactly 60 tick_1hz pulses; sec_val=0, min_val=1, hour_val=0.
3. Set hour=23 (23 inc events in SET_HOUR) and min=59 (59 inc events in SET_MIN), return to RUN, wait 60 ticks → hour_val=0, min_val=0, sec_val=0.
4. In SET_MIN from min=5, give 60 inc events → min_val=5, hour_val unchanged, sec_val frozen, no tick_1hz pulses.
5. btn_inc held high for 20 cycles in SET_HOUR → hour_val increases by exactly 1; btn_inc pulse in RUN → no value change.
6. Rising edges of btn_mode and btn_inc in the same cycle in SET_HOUR → set_mode=2, hour_val unchanged. Assert rst while in SET_MIN → set_mode=0, all values 0.

Source files
------------

// File: rtl/time_counter.sv
// Timekeeping core: 1 Hz prescaler, 24 h sec/min/hour counters and a two-button
// set mode (RUN -> SET_HOUR -> SET_MIN -> RUN). All outputs are registered.
module time_counter #(
    parameter int TICK_DIV = 50000000,
    parameter int DIV_W    = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [5:0] sec_val,
    output logic [5:0] min_val,
    output logic [4:0] hour_val,
    output logic [1:0] set_mode,
    output logic       tick_1hz
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SET_HOUR = 2'd1,
        ST_SET_MIN  = 2'd2,
        ST_BAD      = 2'd3
    } state_t;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam int               N_BTN    = 2;

    state_t           state_reg;
    logic [DIV_W-1:0] presc_reg;
    logic             tick_reg;
    logic [5:0]       sec_reg;
    logic [5:0]       min_reg;
    logic [4:0]       hour_reg;

    logic btn_lvl      [N_BTN];
    logic btn_prev_reg [N_BTN];
    logic btn_event    [N_BTN];

    assign btn_lvl[0] = btn_mode;
    assign btn_lvl[1] = btn_inc;

    // A held button yields one event: level high now, low in the previous cycle.
    genvar gi;
    generate
        for (gi = 0; gi < N_BTN; gi++) begin : g_edge
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    btn_prev_reg[gi] <= 1'b0;
                end else begin
                    btn_prev_reg[gi] <= btn_lvl[gi];
                end
            end
            assign btn_event[gi] = btn_lvl[gi] & ~btn_prev_reg[gi];
        end
    endgenerate

    logic       mode_ev;
    logic       inc_ev;
    logic       sec_wrap;
    logic       min_wrap;
    logic [5:0] sec_inc;
    logic [5:0] min_inc;
    logic [4:0] hour_inc;

    assign mode_ev  = btn_event[0];
    assign inc_ev   = btn_event[1];
    assign sec_wrap = (sec_reg == 6'd59);
    assign min_wrap = (min_reg == 6'd59);
    assign sec_inc  = sec_wrap ? 6'd0 : sec_reg + 6'd1;
    assign min_inc  = min_wrap ? 6'd0 : min_reg + 6'd1;
    assign hour_inc = (hour_reg == 5'd23) ? 5'd0 : hour_reg + 5'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_RUN;
            presc_reg <= '0;
            tick_reg  <= 1'b0;
            sec_reg   <= '0;
            min_reg   <= '0;
            hour_reg  <= '0;
        end else begin
            tick_reg <= 1'b0;
            case (state_reg)
                ST_RUN: begin
                    if (presc_reg == DIV_LAST) begin
                        presc_reg <= '0;
                        tick_reg  <= 1'b1;
                        sec_reg   <= sec_inc;
                        if (sec_wrap) begin
                            min_reg <= min_inc;
                            if (min_wrap) begin
                                hour_reg <= hour_inc;
                            end
                        end
                    end else begin
                        presc_reg <= presc_reg + DIV_W'(1);
                    end
                    // A tick in the leaving cycle still counts; the prescaler
                    // then parks at 0 for the set states.
                    if (mode_ev) begin
                        state_reg <= ST_SET_HOUR;
                        presc_reg <= '0;
                    end
                end
                ST_SET_HOUR: begin
                    presc_reg <= '0;
                    if (mode_ev) begin
                        state_reg <= ST_SET_MIN;
                    end else if (inc_ev) begin
                        hour_reg <= hour_inc;
                    end
                end
                ST_SET_MIN: begin
                    presc_reg <= '0;
                    if (mode_ev) begin
                        state_reg <= ST_RUN;
                        sec_reg   <= '0;
                    end else if (inc_ev) begin
                        min_reg <= min_inc;
                    end
                end
                default: begin
                    state_reg <= ST_RUN;
                    presc_reg <= '0;
                end
            endcase
        end
    end

    assign sec_val  = sec_reg;
    assign min_val  = min_reg;
    assign hour_val = hour_reg;
    assign set_mode = state_reg;
    assign tick_1hz = tick_reg;

endmodule

// File: tb/tb_time_counter.sv
// Randomised and directed bench for time_counter against a seconds-of-day model.
module tb_time_counter;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [5:0] sec_val;
    logic [5:0] min_val;
    logic [4:0] hour_val;
    logic [1:0] set_mode;
    logic       tick_1hz;

    time_counter #(.TICK_DIV(TD), .DIV_W(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .sec_val  (sec_val),
        .min_val  (min_val),
        .hour_val (hour_val),
        .set_mode (set_mode),
        .tick_1hz (tick_1hz)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: time of day in seconds, mode, cycles spent running.
    int m_tod;
    int m_mode;
    int m_run_cnt;
    bit m_prev_m;
    bit m_prev_i;
    bit m_tick;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string where);
        chk({where, ":sec"},  int'(sec_val),  m_tod % 60);
        chk({where, ":min"},  int'(min_val),  (m_tod / 60) % 60);
        chk({where, ":hour"}, int'(hour_val), m_tod / 3600);
        chk({where, ":mode"}, int'(set_mode), m_mode);
        chk({where, ":tick"}, int'(tick_1hz), int'(m_tick));
    endtask

    task automatic model_reset();
        m_tod = 0; m_mode = 0; m_run_cnt = 0;
        m_prev_m = 1'b0; m_prev_i = 1'b0; m_tick = 1'b0;
    endtask

    task automatic model_step(input bit m, input bit i);
        bit mev, iev;
        int h, mi, s;
        mev = m && !m_prev_m;
        iev = i && !m_prev_i;
        m_prev_m = m;
        m_prev_i = i;
        m_tick = 1'b0;
        h = m_tod / 3600; mi = (m_tod / 60) % 60; s = m_tod % 60;
        if (m_mode == 0) begin
            m_run_cnt++;
            if (m_run_cnt % TD == 0) begin
                m_tick = 1'b1;
                m_tod = (m_tod + 1) % 86400;
            end
            if (mev) begin
                m_mode = 1;
                m_run_cnt = 0;
            end
        end else if (m_mode == 1) begin
            if (mev) m_mode = 2;
            else if (iev) m_tod = ((h + 1) % 24) * 3600 + mi * 60 + s;
        end else begin
            if (mev) begin
                m_mode = 0;
                m_run_cnt = 0;
                m_tod = h * 3600 + mi * 60;
            end else if (iev) begin
                m_tod = h * 3600 + ((mi + 1) % 60) * 60 + s;
            end
        end
    endtask

    int ticks_seen = 0;

    task automatic cycle(input bit m, input bit i);
        btn_mode = m;
        btn_inc  = i;
        @(posedge clk);
        model_step(m, i);
        #1;
        if (tick_1hz) ticks_seen++;
        check_all("cyc");
    endtask

    task automatic press_mode();
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
    endtask

    task automatic press_inc();
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
    endtask

    task automatic do_reset(input int n);
        #2;
        rst = 1'b0;
        btn_mode = 1'b0;
        btn_inc = 1'b0;
        model_reset();
        #1;
        check_all("rst_async");
        repeat (n) @(posedge clk);
        #1;
        check_all("rst_hold");
        rst = 1'b1;
    endtask

    task automatic first_tick_latency(input string tag);
        int cnt;
        cnt = 0;
        ticks_seen = 0;
        while (ticks_seen == 0 && cnt < 3 * TD) begin
            cycle(1'b0, 1'b0);
            cnt++;
        end
        chk(tag, cnt, TD);
    endtask

    initial begin
        bit bm, bi;
        model_reset();
        do_reset(2);
        $display("reset released, checking first tick latency and 240 run cycles");

        first_tick_latency("first_tick_after_reset");
        repeat (240 - TD) cycle(1'b0, 1'b0);
        chk("ticks_in_240", ticks_seen, 60);
        chk("run240_sec", int'(sec_val), 0);
        chk("run240_min", int'(min_val), 1);
        chk("run240_hour", int'(hour_val), 0);

        repeat (2) cycle(1'b0, 1'b0);
        do_reset(3);
        $display("mid-count reset for 3 cycles");
        first_tick_latency("first_tick_after_midreset");

        $display("setting 23:59 and rolling over");
        press_mode();
        repeat (23) press_inc();
        press_mode();
        repeat (59) press_inc();
        press_mode();
        chk("set_hour23", int'(hour_val), 23);
        chk("set_min59", int'(min_val), 59);
        chk("set_exit_sec", int'(sec_val), 0);
        chk("set_exit_mode", int'(set_mode), 0);
        repeat (240) cycle(1'b0, 1'b0);
        chk("rollover_hour", int'(hour_val), 0);
        chk("rollover_min", int'(min_val), 0);
        chk("rollover_sec", int'(sec_val), 0);

        $display("SET_MIN wrap without carry");
        press_mode();
        press_mode();
        repeat (5) press_inc();
        ticks_seen = 0;
        repeat (60) press_inc();
        chk("setmin_wrap_min", int'(min_val), 5);
        chk("setmin_wrap_hour", int'(hour_val), 0);
        chk("setmin_frozen_sec", int'(sec_val), 0);
        chk("setmin_no_ticks", ticks_seen, 0);

        $display("held inc in SET_HOUR, inc pulse in RUN");
        press_mode();
        press_mode();
        repeat (20) cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        chk("held_inc_hour", int'(hour_val), 1);
        press_mode();
        press_mode();
        press_inc();
        chk("run_inc_hour", int'(hour_val), 1);
        chk("run_inc_min", int'(min_val), 5);

        $display("simultaneous mode+inc in SET_HOUR, reset in SET_MIN");
        press_mode();
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b0);
        chk("simul_mode", int'(set_mode), 2);
        chk("simul_hour", int'(hour_val), 1);
        do_reset(2);
        chk("reset_in_setmin_mode", int'(set_mode), 0);

        $display("random button stimulus");
        bm = 1'b0;
        bi = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 7) == 0) bm = ~bm;
            if ($urandom_range(0, 3) == 0) bi = ~bi;
            if ($urandom_range(0, 1499) == 0) begin
                do_reset($urandom_range(1, 3));
                bm = 1'b0;
                bi = 1'b0;
            end else begin
                cycle(bm, bi);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
